// File: rtl/energy_accumulator.sv
// Sums DATASPIN signed local energies per frame; total valid 1 cycle after last input, held (input stalled) until accepted.
// Optional ENERGY_MIN_TRACK_EN compiles in running-minimum tracking of transferred totals.
module energy_accumulator #(
  parameter int LOCAL_ENERGY_BIT = 16,
  parameter int DATASPIN         = 256,
  parameter int TOTAL_ENERGY_BIT = 32,
  parameter int FRAME_CNT_BIT    = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               clear_i,
  input  logic                               energy_valid_i,
  output logic                               energy_ready_o,
  input  logic signed [LOCAL_ENERGY_BIT-1:0] energy_i,
  output logic                               total_valid_o,
  input  logic                               total_ready_i,
  output logic signed [TOTAL_ENERGY_BIT-1:0] total_energy_o,
  output logic        [FRAME_CNT_BIT-1:0]    frame_cnt_o,
  output logic signed [TOTAL_ENERGY_BIT-1:0] min_energy_o,
  output logic                               min_valid_o
);

  localparam int CNT_W = (DATASPIN > 2) ? $clog2(DATASPIN) : 1;
  localparam logic [CNT_W-1:0] LAST_SPIN = CNT_W'(DATASPIN - 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t                              r_state;
  state_t                              w_state_nxt;
  logic signed [TOTAL_ENERGY_BIT-1:0]  r_acc;
  logic        [CNT_W-1:0]             r_cnt;
  logic signed [TOTAL_ENERGY_BIT-1:0]  r_total;
  logic        [FRAME_CNT_BIT-1:0]     r_frame_cnt;
  logic signed [TOTAL_ENERGY_BIT-1:0]  w_energy_ext;
  logic signed [TOTAL_ENERGY_BIT-1:0]  w_acc_sum;
  logic                                w_in_xfer;
  logic                                w_out_xfer;
  logic                                w_last;

  assign w_energy_ext = {{(TOTAL_ENERGY_BIT-LOCAL_ENERGY_BIT){energy_i[LOCAL_ENERGY_BIT-1]}}, energy_i};
  assign w_acc_sum    = r_acc + w_energy_ext;

  // Handshakes are suppressed by clear_i so an aborted cycle never counts.
  always_comb begin
    w_state_nxt    = r_state;
    energy_ready_o = (r_state == ACCUM);
    total_valid_o  = (r_state == HOLD);
    w_in_xfer      = energy_valid_i && energy_ready_o && !clear_i;
    w_out_xfer     = total_valid_o && total_ready_i && !clear_i;
    w_last         = w_in_xfer && (r_cnt == LAST_SPIN);
    if (clear_i) begin
      w_state_nxt = ACCUM;
    end else begin
      case (r_state)
        ACCUM:   if (w_last)     w_state_nxt = HOLD;
        HOLD:    if (w_out_xfer) w_state_nxt = ACCUM;
        default: w_state_nxt = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_total     <= '0;
      r_frame_cnt <= '0;
    end else if (clear_i) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else begin
      if (w_last) begin
        r_total <= w_acc_sum;
        r_acc   <= '0;
        r_cnt   <= '0;
      end else if (w_in_xfer) begin
        r_acc <= w_acc_sum;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_out_xfer) begin
        r_frame_cnt <= r_frame_cnt + FRAME_CNT_BIT'(1);
      end
    end
  end

  assign total_energy_o = r_total;
  assign frame_cnt_o    = r_frame_cnt;

`ifdef ENERGY_MIN_TRACK_EN
  logic signed [TOTAL_ENERGY_BIT-1:0] r_min;
  logic                               r_min_vld;

  // Strict less-than: a tie keeps the earlier minimum.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_min     <= '0;
      r_min_vld <= 1'b0;
    end else if (w_out_xfer && (!r_min_vld || (r_total < r_min))) begin
      r_min     <= r_total;
      r_min_vld <= 1'b1;
    end
  end

  assign min_energy_o = r_min;
  assign min_valid_o  = r_min_vld;
`else
  assign min_energy_o = '0;
  assign min_valid_o  = 1'b0;
`endif

endmodule

// File: tb/tb_energy_accumulator.sv
// Directed bench for energy_accumulator (DATASPIN=4, 16-bit inputs, 18-bit totals, 3-bit frame counter).
module tb_energy_accumulator;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               clear_i;
  logic               energy_valid_i;
  logic               energy_ready_o;
  logic signed [15:0] energy_i;
  logic               total_valid_o;
  logic               total_ready_i;
  logic signed [17:0] total_energy_o;
  logic        [2:0]  frame_cnt_o;
  logic signed [17:0] min_energy_o;
  logic               min_valid_o;

  int n_checks = 0;
  int n_errors = 0;
  int exp_frame = 0;
  int exp_min = 0;
  bit exp_min_vld = 1'b0;

  energy_accumulator #(
    .LOCAL_ENERGY_BIT(16),
    .DATASPIN        (4),
    .TOTAL_ENERGY_BIT(18),
    .FRAME_CNT_BIT   (3)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .clear_i       (clear_i),
    .energy_valid_i(energy_valid_i),
    .energy_ready_o(energy_ready_o),
    .energy_i      (energy_i),
    .total_valid_o (total_valid_o),
    .total_ready_i (total_ready_i),
    .total_energy_o(total_energy_o),
    .frame_cnt_o   (frame_cnt_o),
    .min_energy_o  (min_energy_o),
    .min_valid_o   (min_valid_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_min();
`ifdef ENERGY_MIN_TRACK_EN
    check("min_energy", min_energy_o, exp_min);
    check("min_valid", min_valid_o, exp_min_vld);
`else
    check("min_energy_off", min_energy_o, 0);
    check("min_valid_off", min_valid_o, 0);
`endif
  endtask

  // Feeds four back-to-back inputs, stalls the consumer for hold_cycles, then accepts.
  task automatic run_frame(input int e0, input int e1, input int e2, input int e3,
                           input int exp_total, input int hold_cycles);
    int e[4];
    e = '{e0, e1, e2, e3};
    total_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      energy_valid_i = 1'b1;
      energy_i       = 16'(e[i]);
      step();
      if (i == 2) check("valid_early", total_valid_o, 0);
    end
    energy_valid_i = 1'b0;
    check("total_valid", total_valid_o, 1);
    check("total_value", total_energy_o, exp_total);
    check("ready_in_hold", energy_ready_o, 0);
    for (int c = 0; c < hold_cycles; c++) begin
      energy_valid_i = 1'b1;
      energy_i       = 16'sd1234;
      step();
      check("hold_valid", total_valid_o, 1);
      check("hold_total", total_energy_o, exp_total);
      check("hold_ready", energy_ready_o, 0);
    end
    energy_valid_i = 1'b0;
    total_ready_i  = 1'b1;
    step();
    total_ready_i = 1'b0;
    exp_frame = (exp_frame + 1) % 8;
    if (!exp_min_vld || exp_total < exp_min) begin
      exp_min     = exp_total;
      exp_min_vld = 1'b1;
    end
    check("post_valid", total_valid_o, 0);
    check("post_ready", energy_ready_o, 1);
    check("total_kept", total_energy_o, exp_total);
    check("frame_cnt", frame_cnt_o, exp_frame);
    check_min();
  endtask

  initial begin
    rst_i          = 1'b1;
    clear_i        = 1'b0;
    energy_valid_i = 1'b0;
    energy_i       = '0;
    total_ready_i  = 1'b0;
    step();
    step();
    rst_i = 1'b0;
    check("rst_ready", energy_ready_o, 1);
    check("rst_valid", total_valid_o, 0);
    check("rst_total", total_energy_o, 0);
    check("rst_frame", frame_cnt_o, 0);
    check_min();

    run_frame(5, -3, 7, -1, 8, 0);
    run_frame(1, 2, 3, 4, 10, 4);

    // Reset while in HOLD with the consumer ready: no transfer may count.
    total_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      energy_valid_i = 1'b1;
      energy_i       = 16'sd2;
      step();
    end
    energy_valid_i = 1'b0;
    check("pre_rst_hold", total_valid_o, 1);
    rst_i         = 1'b1;
    total_ready_i = 1'b1;
    step();
    rst_i         = 1'b0;
    total_ready_i = 1'b0;
    exp_frame   = 0;
    exp_min     = 0;
    exp_min_vld = 1'b0;
    check("rst_hold_valid", total_valid_o, 0);
    check("rst_hold_frame", frame_cnt_o, 0);
    check("rst_hold_ready", energy_ready_o, 1);
    check("rst_hold_total", total_energy_o, 0);
    check_min();

    run_frame(4, 3, 2, 1, 10, 0);
    run_frame(-1, -1, -1, -1, -4, 0);
    run_frame(-2, -2, 1, -1, -4, 1);
    run_frame(1, 1, 1, 0, 3, 0);
    run_frame(-32768, -32768, -32768, -32768, -131072, 0);
    run_frame(32767, 32767, 32767, 32767, 131068, 0);

    // Abort mid-frame with an input offered in the clear cycle.
    energy_valid_i = 1'b1;
    energy_i       = 16'sd100;
    step();
    step();
    clear_i  = 1'b1;
    energy_i = 16'sd50;
    step();
    clear_i        = 1'b0;
    energy_valid_i = 1'b0;
    check("clr_ready", energy_ready_o, 1);
    check("clr_valid", total_valid_o, 0);
    check("clr_frame", frame_cnt_o, exp_frame);
    run_frame(1, 1, 1, 1, 4, 0);

    // Clear in HOLD wins over a same-cycle output transfer.
    for (int i = 0; i < 4; i++) begin
      energy_valid_i = 1'b1;
      energy_i       = 16'sd3;
      step();
    end
    energy_valid_i = 1'b0;
    check("clr_hold_pre", total_valid_o, 1);
    clear_i       = 1'b1;
    total_ready_i = 1'b1;
    step();
    clear_i       = 1'b0;
    total_ready_i = 1'b0;
    check("clr_hold_valid", total_valid_o, 0);
    check("clr_hold_frame", frame_cnt_o, exp_frame);
    check("clr_hold_ready", energy_ready_o, 1);
    check_min();

    // Eighth frame since reset wraps the 3-bit frame counter to 0.
    run_frame(1, 2, 3, -6, 0, 0);
    check("frame_wrap", frame_cnt_o, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/energy_accumulator.md
ENERGY_ACCUMULATOR -- requirements
Module: energy_accumulator

Interface
REQ-001 SHALL have parameter LOCAL_ENERGY_BIT, default 16, width of each signed per-spin local energy input.
REQ-002 SHALL have parameter DATASPIN, default 256, number of local energies summed per frame (≥2).
REQ-003 SHALL have parameter TOTAL_ENERGY_BIT, default 32, width of the signed total energy; it SHALL be ≥ LOCAL_ENERGY_BIT+$clog2(DATASPIN).
REQ-004 SHALL have parameter FRAME_CNT_BIT, default 16, width of the frame counter.
REQ-005 Ports: clk_i  in  1  clock; all logic on its rising edge.
REQ-006 Ports: rst_i  in  1  reset; one clock, synchronous, active-high.
REQ-007 Ports: clear_i  in  1  synchronous frame abort.
REQ-008 Ports: energy_valid_i  in  1  local energy valid.
REQ-009 Ports: energy_ready_o  out  1  accumulator accepts a local energy.
REQ-010 Ports: energy_i  in  LOCAL_ENERGY_BIT  signed local energy from partial_energy_calc.
REQ-011 Ports: total_valid_o  out  1  frame total available.
REQ-012 Ports: total_ready_i  in  1  consumer accepts the total.
REQ-013 Ports: total_energy_o  out  TOTAL_ENERGY_BIT  signed frame total.
REQ-014 Ports: frame_cnt_o  out  FRAME_CNT_BIT  number of totals transferred.
REQ-015 Ports: min_energy_o  out  TOTAL_ENERGY_BIT  lowest total seen; min_valid_o  out  1  min_energy_o is meaningful.

Function
REQ-016 SHALL implement two states: ACCUM and HOLD.
REQ-017 ACCUM: energy_ready_o=1; each input transfer (valid&&ready) SHALL add the sign-extended energy_i to the accumulator and increment the spin counter.
REQ-018 On the transfer with spin counter == DATASPIN-1, the block SHALL load total_energy_o with accumulator+energy_i, clear the accumulator and counter, and enter HOLD.
REQ-019 total_valid_o SHALL assert in the cycle after the last input transfer (latency 1) and only in HOLD.
REQ-020 HOLD: energy_ready_o=0; total_energy_o and total_valid_o SHALL stay stable until total_valid_o&&total_ready_i, then return to ACCUM in the next cycle.
REQ-021 A total transfer SHALL increment frame_cnt_o, which wraps from 2^FRAME_CNT_BIT-1 to 0.
REQ-022 Accumulation SHALL be two's-complement modulo 2^TOTAL_ENERGY_BIT; no saturation.
REQ-023 energy_valid_i without energy_ready_o SHALL leave all state unchanged.
REQ-024 clear_i SHALL, in the next cycle, zero accumulator and counter, deassert total_valid_o, enter ACCUM; frame_cnt_o and min tracking SHALL be unaffected.
REQ-025 clear_i SHALL take priority over any input or output transfer in the same cycle; neither transfer counts.
REQ-026 total_energy_o SHALL hold its last value outside HOLD.

Reset
REQ-027 rst_i SHALL force state ACCUM, accumulator=0, counter=0, total_energy_o=0, total_valid_o=0, frame_cnt_o=0, min_energy_o=0, min_valid_o=0; energy_ready_o=1 in the first cycle after reset.
REQ-028 rst_i SHALL take priority over clear_i and all handshakes, including mid-frame and in HOLD.

Configuration
REQ-029 Macro ENERGY_MIN_TRACK_EN SHALL compile in minimum tracking.
REQ-030 With ENERGY_MIN_TRACK_EN: on each total transfer, if min_valid_o=0 or total_energy_o < min_energy_o (signed), min_energy_o SHALL load total_energy_o and min_valid_o SHALL set, visible next cycle; ties do not update.
REQ-031 Without ENERGY_MIN_TRACK_EN: min_energy_o and min_valid_o SHALL be constant 0 and no comparison logic SHALL exist.

Verification
REQ-032 DATASPIN=4; inputs 5,-3,7,-1 back-to-back, total_ready_i=1 -> total_valid_o one cycle after the 4th transfer, total_energy_o=8, frame_cnt_o=1.
REQ-033 DATASPIN=4; total_ready_i=0 for 5 cycles after total_valid_o -> energy_ready_o=0 and total stable throughout; fifth-cycle accept -> ACCUM next cycle.
REQ-034 LOCAL_ENERGY_BIT=16, TOTAL_ENERGY_BIT=18, DATASPIN=4; four inputs of -32768 -> total_energy_o=-131072; 32767 ×4 -> 131068.
REQ-035 Two inputs accepted, then clear_i with energy_valid_i=1 -> input not counted; next four inputs 1,1,1,1 -> total 4.
REQ-036 With ENERGY_MIN_TRACK_EN, frames totalling 10, -4, -4, 3 -> min_energy_o 10, -4, -4, -4; min_valid_o=1 from first transfer; without macro -> both outputs 0.
REQ-037 rst_i asserted in HOLD with total_ready_i=1 -> no transfer, frame_cnt_o=0, total_valid_o=0 next cycle.
